seg_disp_scan: RTL and testbench

SEG_DISP_SCAN -- requirements
Module: seg_disp_scan

---
 rtl/seg_pkg.sv | 25 ++
 rtl/seg_hex_decode.sv | 19 +
 rtl/seg_disp_scan.sv | 152 +++++++++++++++
 tb/tb_seg_disp_scan.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// ============================================================================
// Module : seg_pkg
// Brief  : Shared types and constants for the 7-segment scan display.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seg_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}, indexed by hex value
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

`default_nettype wire

// File: rtl/seg_hex_decode.sv
// ============================================================================
// Module : seg_hex_decode
// Brief  : Combinational hex nibble to active-low 7-segment pattern.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_LUT[nib_i];

endmodule

`default_nettype wire

// File: rtl/seg_disp_scan.sv
// ============================================================================
// Module : seg_disp_scan
// Brief  : Multiplexed 7-segment scanner with shadowed, frame-aligned update.
//          Define SEG_LZB_EN to blank leading-zero digits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_disp_scan
    import seg_pkg::*;
#(
    parameter int NUM_DIG     = 4,
    parameter int DRIVE_TICKS = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 tick_i,
    input  logic [4*NUM_DIG-1:0] data_i,
    input  logic                 data_vld_i,
    output logic                 data_rdy_o,
    output logic [NUM_DIG-1:0]   an_o,
    output logic [6:0]           seg_o
);

    localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int CNT_W = (DRIVE_TICKS > 1) ? $clog2(DRIVE_TICKS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIG - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRIVE_TICKS - 1);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   pend_q, pend_d;
    logic [4*NUM_DIG-1:0]   shadow_q, shadow_d;
    logic [4*NUM_DIG-1:0]   disp_q, disp_d;
    logic [NUM_DIG-1:0]     an_q, an_d;
    logic [6:0]             seg_q, seg_d;

    logic                   accept;
    logic                   frame_end;
    logic [3:0]             nibs [NUM_DIG];
    logic [6:0]             hex_seg;
    logic                   blank_dig;

    assign data_rdy_o = ~pend_q;
    assign accept     = data_vld_i & ~pend_q;
    assign frame_end  = tick_i && (state_q == DRIVE) && (cnt_q == CNT_LAST)
                        && (idx_q == IDX_LAST);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (tick_i) begin
            if (state_q == BLANK) begin
                state_d = DRIVE;
                cnt_d   = '0;
            end else if (cnt_q != CNT_LAST) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                state_d = BLANK;
                cnt_d   = '0;
                idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end
        end
    end

    // Transfer and acceptance are mutually exclusive: accept needs pend_q=0
    always_comb begin
        shadow_d = accept ? data_i : shadow_q;
        pend_d   = pend_q;
        disp_d   = disp_q;
        if (frame_end && pend_q) begin
            disp_d = shadow_q;
            pend_d = 1'b0;
        end else if (accept) begin
            pend_d = 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_DIG; k++) begin
            nibs[k] = disp_d[4*k +: 4];
        end
    end

    seg_hex_decode u_dec (
        .nib_i (nibs[idx_d]),
        .seg_o (hex_seg)
    );

`ifdef SEG_LZB_EN
    logic [NUM_DIG-1:0] lz;
    logic               lz_acc;

    // lz[k] is set when nibble k and every nibble above it are zero
    always_comb begin
        lz_acc = 1'b1;
        lz     = '0;
        for (int k = NUM_DIG - 1; k >= 0; k--) begin
            lz_acc = lz_acc & (nibs[k] == 4'h0);
            lz[k]  = lz_acc;
        end
    end

    assign blank_dig = (idx_d != '0) && lz[idx_d];
`else
    assign blank_dig = 1'b0;
`endif

    always_comb begin
        an_d  = an_q;
        seg_d = seg_q;
        if (tick_i) begin
            if (state_d == DRIVE) begin
                an_d  = ~(NUM_DIG'(1) << idx_d);
                seg_d = blank_dig ? SEG_OFF : hex_seg;
            end else begin
                an_d  = '1;
                seg_d = SEG_OFF;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= BLANK;
            idx_q    <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            shadow_q <= '0;
            disp_q   <= '0;
            an_q     <= '1;
            seg_q    <= SEG_OFF;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign an_o  = an_q;
    assign seg_o = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_disp_scan.sv
// ============================================================================
// Module : tb_seg_disp_scan
// Brief  : Scoreboard bench for seg_disp_scan (default and DRIVE_TICKS=1).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_seg_disp_scan;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic        tick1 = 1'b0, vld1 = 1'b0;
    logic        tick2 = 1'b0, vld2 = 1'b0;
    logic [15:0] data1 = '0, data2 = '0;
    logic        rdy1, rdy2;
    logic [3:0]  an1, an2;
    logic [6:0]  seg1, seg2;

    int errors = 0;
    int checks = 0;

`ifdef SEG_LZB_EN
    localparam logic [6:0] LZ_SEG = 7'h7F;
`else
    localparam logic [6:0] LZ_SEG = 7'h40;
`endif

    always #5 clk = ~clk;

    seg_disp_scan #(.NUM_DIG(4), .DRIVE_TICKS(3)) u_dut1 (
        .clk        (clk),
        .rstn       (rstn),
        .tick_i     (tick1),
        .data_i     (data1),
        .data_vld_i (vld1),
        .data_rdy_o (rdy1),
        .an_o       (an1),
        .seg_o      (seg1)
    );

    seg_disp_scan #(.NUM_DIG(4), .DRIVE_TICKS(1)) u_dut2 (
        .clk        (clk),
        .rstn       (rstn),
        .tick_i     (tick2),
        .data_i     (data2),
        .data_vld_i (vld2),
        .data_rdy_o (rdy2),
        .an_o       (an2),
        .seg_o      (seg2)
    );

    typedef struct {
        string      name;
        int         unit;
        logic [3:0] an;
        logic [6:0] seg;
        logic       rdy;
    } exp_t;

    exp_t sb[$];

    // Monitor: compares every queued expectation at the falling edge
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t       e;
            logic [3:0] a;
            logic [6:0] s;
            logic       r;
            e = sb.pop_front();
            a = (e.unit == 0) ? an1  : an2;
            s = (e.unit == 0) ? seg1 : seg2;
            r = (e.unit == 0) ? rdy1 : rdy2;
            checks++;
            if (a !== e.an || s !== e.seg || r !== e.rdy) begin
                errors++;
                $display("FAIL %s: got an=%b seg=%h rdy=%b, want an=%b seg=%h rdy=%b",
                         e.name, a, s, r, e.an, e.seg, e.rdy);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string name, input int unit, input logic [3:0] an,
                            input logic [6:0] seg, input logic rdy);
        exp_t e;
        e.name = name; e.unit = unit; e.an = an; e.seg = seg; e.rdy = rdy;
        sb.push_back(e);
    endtask

    initial begin
        // Reset state
        cyc(2);
        push_exp("reset_state_u0", 0, 4'hF, 7'h7F, 1'b1);
        push_exp("reset_state_u1", 1, 4'hF, 7'h7F, 1'b1);
        cyc(1);
        rstn = 1'b1; tick1 = 1'b1; vld1 = 1'b1; data1 = 16'hBEEF;
        cyc(1);
        push_exp("first_drive", 0, 4'hE, 7'h40, 1'b0);
        vld1 = 1'b0;
        cyc(1);
        // Asynchronous reset mid-DRIVE, pending BEEF discarded
        rstn = 1'b0;
        push_exp("rst_async", 0, 4'hF, 7'h7F, 1'b1);
        cyc(1);
        rstn = 1'b1; vld1 = 1'b1; data1 = 16'h1234;

        // Load: shown only after the frame boundary (E16)
        cyc(1);   // E1
        push_exp("old_data", 0, 4'hE, 7'h40, 1'b0);
        vld1 = 1'b0;
        cyc(14);  // E15
        push_exp("pre_boundary", 0, 4'h7, 7'h40, 1'b0);
        cyc(1);   // E16
        push_exp("boundary", 0, 4'hF, 7'h7F, 1'b1);
        cyc(1);   // E17
        push_exp("load_dig0", 0, 4'hE, 7'h19, 1'b1);
        cyc(4);   // E21
        push_exp("load_dig1", 0, 4'hD, 7'h30, 1'b1);

        // Backpressure: AAAA then 5555 offered immediately
        data1 = 16'hAAAA; vld1 = 1'b1;
        cyc(1);   // E22
        push_exp("bp_accept", 0, 4'hD, 7'h30, 1'b0);
        data1 = 16'h5555;
        cyc(9);   // E31
        push_exp("bp_held", 0, 4'h7, 7'h79, 1'b0);
        cyc(1);   // E32
        push_exp("bp_transfer", 0, 4'hF, 7'h7F, 1'b1);
        cyc(1);   // E33
        push_exp("bp_next_accept", 0, 4'hE, 7'h08, 1'b0);
        vld1 = 1'b0;
        cyc(15);  // E48
        push_exp("bp_boundary2", 0, 4'hF, 7'h7F, 1'b1);
        cyc(1);   // E49
        push_exp("bp_5555_shown", 0, 4'hE, 7'h12, 1'b1);

        // Leading zeros
        data1 = 16'h0005; vld1 = 1'b1;
        cyc(1);   // E50
        vld1 = 1'b0;
        cyc(15);  // E65
        push_exp("lz_dig0", 0, 4'hE, 7'h12, 1'b1);
        cyc(4);
        push_exp("lz_dig1", 0, 4'hD, LZ_SEG, 1'b1);
        cyc(4);
        push_exp("lz_dig2", 0, 4'hB, LZ_SEG, 1'b1);
        cyc(4);   // E77: DRIVE idx3 cnt0
        push_exp("lz_dig3", 0, 4'h7, LZ_SEG, 1'b1);

        // Tick stall
        tick1 = 1'b0;
        cyc(100);
        push_exp("stall_hold", 0, 4'h7, LZ_SEG, 1'b1);
        tick1 = 1'b1;
        cyc(2);
        push_exp("resume_drive", 0, 4'h7, LZ_SEG, 1'b1);
        cyc(1);
        push_exp("resume_blank", 0, 4'hF, 7'h7F, 1'b1);

        // DRIVE_TICKS=1: 8-tick frame
        tick2 = 1'b1; vld2 = 1'b1; data2 = 16'h1234;
        cyc(1);   // F1
        push_exp("t1_drive0", 1, 4'hE, 7'h40, 1'b0);
        vld2 = 1'b0;
        cyc(1);   // F2
        push_exp("t1_blank", 1, 4'hF, 7'h7F, 1'b0);
        cyc(1);   // F3
        push_exp("t1_drive1", 1, 4'hD, 7'h40, 1'b0);
        cyc(4);   // F7
        push_exp("t1_drive3", 1, 4'h7, 7'h40, 1'b0);
        cyc(1);   // F8
        push_exp("t1_boundary", 1, 4'hF, 7'h7F, 1'b1);
        cyc(1);   // F9
        push_exp("t1_shown", 1, 4'hE, 7'h19, 1'b1);
        data2 = 16'h5678; vld2 = 1'b1;
        cyc(1);   // F10
        push_exp("t1_accept2", 1, 4'hF, 7'h7F, 1'b0);
        vld2 = 1'b0;
        cyc(5);   // F15
        push_exp("t1_drive3b", 1, 4'h7, 7'h79, 1'b0);
        cyc(1);   // F16
        push_exp("t1_boundary2", 1, 4'hF, 7'h7F, 1'b1);
        cyc(1);   // F17
        push_exp("t1_shown2", 1, 4'hE, 7'h00, 1'b1);

        cyc(2);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
